// File: rtl/pmem_responder.sv
// Line-granular physical-memory responder for the cache pmem interface.
// Answers each line read/write a fixed LATENCY cycles after acceptance.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   pmem_read     line read request, held until pmem_resp
//   pmem_write    line write request, held until pmem_resp
//   pmem_address  byte address; bits [4:0] ignored, upper bits alias
//   pmem_wdata    write line data
//   pmem_rdata    read line data, valid in the pmem_resp cycle and held
//   pmem_resp     one-cycle completion pulse
//   proto_err     sticky: read and write seen together at acceptance
module pmem_responder #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic                  proto_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int   DEPTH  = 1 << DEPTH_LOG2;
    localparam logic L_ONE  = (LATENCY == 1);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nx;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_nx;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_wr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_rdata;
    logic                  r_perr;
    logic [LINE_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_req;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_rd_op;
    logic                  w_commit;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DEPTH_LOG2-1:0] w_rd_idx;

    // Address bits outside the line index are deliberately ignored.
    logic [ADDR_WIDTH-DEPTH_LOG2-1:0] w_unused_addr;

    assign w_unused_addr = {pmem_address[ADDR_WIDTH-1:DEPTH_LOG2+5],
                            pmem_address[4:0]};

    assign w_idx    = pmem_address[DEPTH_LOG2+4:5];
    assign w_req    = pmem_read | pmem_write;
    assign w_accept = (r_state == ST_IDLE) & w_req;

    // RESP is entered straight from IDLE only when LATENCY is 1.
    assign w_enter_resp = (w_accept & L_ONE)
                        | ((r_state == ST_BUSY) & (r_cnt == 8'd1));

    // The read target comes from the live request when entering RESP
    // directly from IDLE, otherwise from the latched transaction.
    assign w_rd_idx = (r_state == ST_IDLE) ? w_idx : r_idx;
    assign w_rd_op  = (r_state == ST_IDLE) ? ~pmem_write : ~r_wr;

    // Writes land on the edge leaving RESP, before any new acceptance.
    assign w_commit = (r_state == ST_RESP) & r_wr;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_cnt_nx   = CNT_LOAD;
                    w_state_nx = L_ONE ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_cnt_nx = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_wr    <= pmem_write;
                r_wdata <= pmem_wdata;
                if (pmem_read & pmem_write) begin
                    r_perr <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (w_enter_resp & w_rd_op) begin
            r_rdata <= r_mem[w_rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign pmem_resp  = (r_state == ST_RESP);
    assign pmem_rdata = r_rdata;
    assign proto_err  = r_perr;

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Synthesizable physical-memory responder: the memory side of the cache-to-pmem line interface (pmem_read / pmem_write / pmem_address / pmem_wdata / pmem_rdata / pmem_resp).
- Holds a small line-granular backing array and answers each cache line request after a fixed, parameterised latency.
- Used in place of the behavioural memory model for cache bring-up, formal checks and FPGA builds.

Parameters:
- LINE_WIDTH, 256, cache line width in bits; lines are 32 bytes.
- ADDR_WIDTH, 32, byte address width.
- DEPTH_LOG2, 4, log2 of the number of lines in the array (16 lines).
- LATENCY, 4, cycles from request acceptance to pmem_resp; legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset: asynchronous, active-low.
- pmem_read  in  1  line read request; held high by the initiator until pmem_resp.
- pmem_write  in  1  line write request; held high by the initiator until pmem_resp.
- pmem_address  in  ADDR_WIDTH  byte address; bits [4:0] ignored.
- pmem_wdata  in  LINE_WIDTH  write line data.
- pmem_rdata  out  LINE_WIDTH  read line data; valid in the pmem_resp cycle.
- pmem_resp  out  1  one-cycle completion pulse.
- proto_err  out  1  sticky flag: pmem_read and pmem_write were seen high together.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - pmem_resp=0, pmem_rdata=0, proto_err=0, latency counter=0.
  - All array lines are cleared to 0.
  - An in-flight transaction is discarded and no write is committed.
- Index: idx = pmem_address[DEPTH_LOG2+4:5]. Upper address bits are ignored, so addresses alias modulo 2^(DEPTH_LOG2+5) bytes.
- States are IDLE, BUSY and RESP.
- IDLE:
  - When pmem_read or pmem_write is high at a rising edge, latch idx, the op (write if pmem_write, else read) and pmem_wdata.
  - On that same edge, load cnt=LATENCY-1.
  - Go to RESP if LATENCY==1, else BUSY.
- BUSY:
  - Decrement cnt each cycle. When cnt reaches 1, go to RESP on the next edge.
  - Request inputs are ignored; dropping the request mid-flight does not cancel it.
- RESP:
  - pmem_resp=1 for exactly this cycle.
  - Read: pmem_rdata = array[latched idx]. The value is registered on the edge entering RESP and is held after RESP until the next read response.
  - Write: array[latched idx] <= latched wdata on the edge leaving RESP. pmem_rdata is unchanged.
  - Always return to IDLE.
- Timing: if the request is accepted at edge E, pmem_resp is high in the cycle following edge E+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Back-to-back: a request still high in the cycle after RESP is accepted as a new transaction. Minimum spacing between pmem_resp pulses is LATENCY+1 cycles.
- Simultaneous read and write at acceptance: the transaction is treated as a write and proto_err is set. proto_err stays 1 until reset.
- Read-after-write to the same line returns the newly written data, because the commit occurs before the next acceptance.
- No combinational path from inputs to outputs; all outputs are registered.
- No X may propagate from the array after reset.

Test Plan:
- Reset, then read 0x00000020 with LATENCY=4 -> pmem_resp high exactly in cycle 4 after acceptance, for 1 cycle; pmem_rdata=0; proto_err=0.
- Write 0x00000040 with wdata={8{32'hDEADBEEF}}, then read 0x00000040 -> rdata={8{32'hDEADBEEF}}; read 0x00000060 -> 0.
- After the previous write, read alias 0x00000240 (idx 2) -> rdata={8{32'hDEADBEEF}}.
- Raise pmem_read and pmem_write together on 0x00000080 with wdata all 1s -> write committed; proto_err=1 and stays 1 through later clean transactions; cleared only by rst low.
- Hold pmem_read high continuously; separately, drop the request one cycle after acceptance:
  - Held high -> pmem_resp pulses every LATENCY+1=5 cycles.
  - Dropped early -> the response still pulses once, and the FSM then idles.
- Assert rst low mid-BUSY on a write to 0x000000A0 -> pmem_resp=0 immediately; a later read of 0x000000A0 returns 0. Repeat with LATENCY=1 -> resp 1 cycle after acceptance.
